clock_enable_gen: RTL and testbench
===================================

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024, giving the consecutive synchronized-lock cycles required before run; legal range 2..65535.
REQ-002 SHALL have port clock_160  in  1  sole clock, the 160 MHz MMCM CLKOUT0; all logic rises on it.
REQ-003 SHALL have port nres  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port pll_locked  in  1  MMCM LOCKED output, asynchronous to clock_160.
REQ-005 SHALL have port clksel  in  3  requested rate: 0=/16, 1=/8, 2=/4, 3=/2, 4=/1; 5..7 reserved, treated as /16.
REQ-006 SHALL have port clk_en  out  1  core clock-enable pulse at the selected rate.
REQ-007 SHALL have port run_resn  out  1  active-low core reset; high only while running.
REQ-008 SHALL have port cur_sel  out  3  selection currently in effect.
REQ-009 SHALL have port sel_ack  out  1  one-cycle pulse when a new selection takes effect.

Function
REQ-010 SHALL pass pll_locked through a two-flop synchronizer; locked_s is the second flop output.
REQ-011 SHALL implement FSM states WAIT, STABLE, RUN.
REQ-012 WAIT: when locked_s=1, go to STABLE with lock counter=0.
REQ-013 STABLE: the lock counter (16 bit) SHALL increment each cycle with locked_s=1; at count LOCK_CYCLES-1, go to RUN.
REQ-014 Any state: locked_s=0 SHALL force WAIT on the next edge and clear the lock counter and div_cnt; this overrides every other transition.
REQ-015 run_resn SHALL be a registered copy of (state==RUN), so it rises one cycle after entering RUN and falls one cycle after leaving it.
REQ-016 div_cnt (4 bit) SHALL be held at 0 outside RUN and increment modulo 16 each cycle in RUN, starting from 0 on the first RUN cycle.
REQ-017 clk_en SHALL equal (state==RUN) AND ((div_cnt & mask)==mask), with mask = divisor-1 from cur_sel; it is decoded from registers only and is glitch-free.
REQ-018 With /N selected and RUN held, clk_en SHALL be high exactly once every N cycles; with /1 it SHALL be high every RUN cycle.
REQ-019 A request is pending when clksel differs from cur_sel; it SHALL be applied only on a RUN cycle with div_cnt==15.
REQ-020 On that apply cycle, cur_sel SHALL take the clksel value on the next edge and sel_ack SHALL pulse high for that one following cycle; clk_en on the apply cycle SHALL follow the old selection.
REQ-021 Outside RUN, a pending clksel SHALL be applied on the next edge, with sel_ack pulsing.
REQ-022 clksel changing again before apply SHALL leave only the latest value applied, with a single sel_ack.
REQ-023 No clk_en period SHALL be shorter than min(old divisor, new divisor) cycles across a switch.

Reset
REQ-024 nres low SHALL asynchronously clear: synchronizer flops, state=WAIT, lock counter=0, div_cnt=0, cur_sel=0, sel_ack=0, run_resn=0, clk_en=0.
REQ-025 Release of nres SHALL take effect on the first clock_160 edge after deassertion; nres asserted mid-RUN SHALL drop run_resn and clk_en immediately, without waiting for a clock.

Verification
REQ-026 LOCK_CYCLES=8, clksel=4, pll_locked rises -> run_resn rises 10 to 11 cycles later, and clk_en is then high every cycle.
REQ-027 RUN, clksel=0 -> clk_en high only when div_cnt=15, i.e. every 16th cycle; set clksel=2 mid-period -> sel_ack at the cycle after div_cnt=15, then clk_en every 4 cycles; no period shorter than 4.
REQ-028 RUN, pll_locked drops for 1 cycle -> run_resn low 3 to 4 cycles later, and run is re-earned only after a full LOCK_CYCLES count.
REQ-029 clksel 4->1->3 within one 16-cycle window -> exactly one sel_ack, with cur_sel=3.
REQ-030 clksel=6 -> clk_en behaves as /16, and cur_sel reads 6.
REQ-031 nres pulsed low mid-RUN -> all outputs reach their reset values asynchronously, and recovery repeats the REQ-026 timing.

Source files
------------

// File: rtl/clock_enable_gen.sv
// Clock-enable generator for a core running off the 160 MHz MMCM output.
// The core clock is never gated: a single-cycle enable pulse is produced at
// /16, /8, /4, /2 or /1 of clock_160, and the core is held in reset until
// the MMCM has reported lock continuously for LOCK_CYCLES synchronized cycles.
// Rate changes are deferred to the end of a 16-cycle divider period so no
// enable period is ever shorter than the faster of the two rates involved.

module clock_enable_gen #(
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic       clock_160,
    input  logic       nres,
    input  logic       pll_locked,
    input  logic [2:0] clksel,
    output logic       clk_en,
    output logic       run_resn,
    output logic [2:0] cur_sel,
    output logic       sel_ack
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Lock count value on which STABLE hands over to RUN.
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

    logic        sync1_q;
    logic        locked_s_q;
    state_t      state_q;
    logic [15:0] lock_cnt_q;
    logic [15:0] lock_cnt_inc;
    logic [3:0]  div_cnt_q;
    logic        run_resn_q;
    logic [2:0]  cur_sel_q;
    logic [2:0]  cur_sel_d;
    logic        sel_ack_q;
    logic        sel_ack_d;
    logic [3:0]  div_mask;
    logic        in_run;
    logic        apply_window;
    logic        sel_pending;

    assign in_run       = (state_q == ST_RUN);
    assign lock_cnt_inc = lock_cnt_q + 16'd1;

    // Two-flop synchronizer bringing the asynchronous LOCKED into clock_160.
    always_ff @(posedge clock_160 or negedge nres) begin
        if (!nres) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // Lock-qualification FSM with the divider counter and registered core reset.
    always_ff @(posedge clock_160 or negedge nres) begin
        if (!nres) begin
            state_q    <= ST_WAIT;
            lock_cnt_q <= 16'd0;
            div_cnt_q  <= 4'd0;
            run_resn_q <= 1'b0;
        end else begin
            run_resn_q <= in_run;
            if (!locked_s_q) begin
                state_q    <= ST_WAIT;
                lock_cnt_q <= 16'd0;
                div_cnt_q  <= 4'd0;
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        state_q    <= ST_STABLE;
                        lock_cnt_q <= 16'd0;
                        div_cnt_q  <= 4'd0;
                    end
                    ST_STABLE: begin
                        lock_cnt_q <= lock_cnt_inc;
                        div_cnt_q  <= 4'd0;
                        if (lock_cnt_inc == LOCK_LAST) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        div_cnt_q <= div_cnt_q + 4'd1;
                    end
                    default: begin
                        state_q    <= ST_WAIT;
                        lock_cnt_q <= 16'd0;
                        div_cnt_q  <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Divider mask for the selection in effect; reserved codes fall back to /16.
    always_comb begin
        div_mask = 4'hF;
        case (cur_sel_q)
            3'd0:    div_mask = 4'hF;
            3'd1:    div_mask = 4'h7;
            3'd2:    div_mask = 4'h3;
            3'd3:    div_mask = 4'h1;
            3'd4:    div_mask = 4'h0;
            default: div_mask = 4'hF;
        endcase
    end

    // A differing request is taken at the end of a divider period, or at once outside RUN.
    always_comb begin
        sel_pending  = (clksel != cur_sel_q);
        apply_window = !in_run || (div_cnt_q == 4'hF);
        cur_sel_d    = cur_sel_q;
        sel_ack_d    = 1'b0;
        if (sel_pending && apply_window) begin
            cur_sel_d = clksel;
            sel_ack_d = 1'b1;
        end
    end

    // Selection register and its one-cycle acknowledge.
    always_ff @(posedge clock_160 or negedge nres) begin
        if (!nres) begin
            cur_sel_q <= 3'd0;
            sel_ack_q <= 1'b0;
        end else begin
            cur_sel_q <= cur_sel_d;
            sel_ack_q <= sel_ack_d;
        end
    end

    // Enable is decoded only from registers, so it drops with the async reset.
    assign clk_en   = in_run && ((div_cnt_q & div_mask) == div_mask);
    assign run_resn = run_resn_q;
    assign cur_sel  = cur_sel_q;
    assign sel_ack  = sel_ack_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen with LOCK_CYCLES=8. A reference model tracks the
// run condition as a streak of synchronized lock samples and the enable as a
// phase-within-16 arithmetic rule; every negedge all outputs are compared.

module tb_clock_enable_gen;

    localparam int LOCK = 8;

    logic       clock_160;
    logic       nres;
    logic       pll_locked;
    logic [2:0] clksel;
    logic       clk_en;
    logic       run_resn;
    logic [2:0] cur_sel;
    logic       sel_ack;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit       mS1, mS2;
    int       mStreak;
    int       mPhase;
    logic [2:0] mCur;
    bit       mAck;
    bit       mRunResn;

    clock_enable_gen #(.LOCK_CYCLES(LOCK)) dut (
        .clock_160 (clock_160),
        .nres      (nres),
        .pll_locked(pll_locked),
        .clksel    (clksel),
        .clk_en    (clk_en),
        .run_resn  (run_resn),
        .cur_sel   (cur_sel),
        .sel_ack   (sel_ack)
    );

    // 160 MHz-ish clock; exact frequency is irrelevant to the behaviour.
    initial clock_160 = 1'b0;
    always #5 clock_160 = ~clock_160;

    function automatic int divisorOf(input logic [2:0] s);
        case (s)
            3'd0:    return 16;
            3'd1:    return 8;
            3'd2:    return 4;
            3'd3:    return 2;
            3'd4:    return 1;
            default: return 16;
        endcase
    endfunction

    function automatic bit modelRun();
        return mStreak >= LOCK;
    endfunction

    function automatic bit modelClkEn();
        return modelRun() && (((mPhase + 1) % divisorOf(mCur)) == 0);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural model: run is earned after LOCK consecutive synchronized lock
    // samples; the enable phase counts cycles since entering run, modulo 16.
    always @(posedge clock_160 or negedge nres) begin : refModel
        bit oldRun;
        bit newRun;
        bit apply;
        if (!nres) begin
            mS1      = 0;
            mS2      = 0;
            mStreak  = 0;
            mPhase   = 0;
            mCur     = 3'd0;
            mAck     = 0;
            mRunResn = 0;
        end else begin
            oldRun   = modelRun();
            apply    = (clksel != mCur) && (!oldRun || mPhase == 15);
            mAck     = apply;
            if (apply) mCur = clksel;
            mRunResn = oldRun;
            if (mS2) begin
                if (mStreak < LOCK) mStreak++;
            end else begin
                mStreak = 0;
            end
            newRun = modelRun();
            mPhase = (oldRun && newRun) ? (mPhase + 1) % 16 : 0;
            mS2    = mS1;
            mS1    = pll_locked;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clock_160) begin
        checkOutput("run_resn", int'(run_resn), int'(mRunResn));
        checkOutput("clk_en",   int'(clk_en),   int'(modelClkEn()));
        checkOutput("cur_sel",  int'(cur_sel),  int'(mCur));
        checkOutput("sel_ack",  int'(sel_ack),  int'(mAck));
    end

    task automatic step();
        @(posedge clock_160);
        #1;
    endtask

    // Count edges until run_resn reaches the wanted level, bounded.
    task automatic edgesUntilRun(input logic level, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            step();
            n++;
            if (run_resn == level) break;
        end
    endtask

    // Wait, bounded, until a selection is in effect while running.
    task automatic waitSelRun(input logic [2:0] s);
        int n;
        n = 0;
        while (!(cur_sel == s && run_resn) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) checkOutput("waitSelRunTimeout", 1, 0);
    endtask

    // Gap between two consecutive enable pulses, bounded.
    task automatic measureGap(output int gap);
        int n;
        n = 0;
        while (!clk_en && n < 64) begin
            @(negedge clock_160);
            n++;
        end
        gap = 0;
        do begin
            @(negedge clock_160);
            gap++;
        end while (!clk_en && gap < 64);
    endtask

    // Random rate requests with occasional one-cycle lock losses.
    task automatic applyStimulus(input int cycles);
        int r;
        for (int i = 0; i < cycles; i++) begin
            step();
            r = $urandom_range(0, 199);
            if (r < 8) clksel = 3'($urandom_range(0, 7));
            pll_locked = (r == 8) ? 1'b0 : 1'b1;
        end
        step();
        pll_locked = 1'b1;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int gap;
        int minGap;
        int lastIdx;
        int acks;

        nres       = 1'b0;
        pll_locked = 1'b0;
        clksel     = 3'd4;
        repeat (3) step();
        checkOutput("rstClkEn",   int'(clk_en),   0);
        checkOutput("rstRunResn", int'(run_resn), 0);
        checkOutput("rstCurSel",  int'(cur_sel),  0);
        checkOutput("rstSelAck",  int'(sel_ack),  0);

        // Lock acquisition at /1.
        nres = 1'b1;
        repeat (3) step();
        pll_locked = 1'b1;
        edgesUntilRun(1'b1, 40, n);
        checkOutput("lockLatency", n, 11);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_160);
            checkOutput("clkEnDiv1", int'(clk_en), 1);
        end

        // Randomized traffic against the model.
        applyStimulus(3000);

        // /16, then switch to /4 mid-period.
        clksel = 3'd0;
        waitSelRun(3'd0);
        measureGap(gap);
        checkOutput("gapDiv16", gap, 16);
        repeat ($urandom_range(1, 12)) step();
        clksel  = 3'd2;
        minGap  = 1000;
        lastIdx = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock_160);
            if (clk_en) begin
                if (lastIdx >= 0 && (i - lastIdx) < minGap) minGap = i - lastIdx;
                lastIdx = i;
            end
        end
        checkOutput("minGapAcrossSwitch", int'(minGap >= 4), 1);
        measureGap(gap);
        checkOutput("gapDiv4", gap, 4);

        // Two requests inside one window collapse into one acknowledge.
        clksel = 3'd4;
        waitSelRun(3'd4);
        n = 0;
        while (mPhase != 1 && n < 40) begin
            step();
            n++;
        end
        clksel = 3'd1;
        step();
        step();
        clksel = 3'd3;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_160);
            if (sel_ack) acks++;
        end
        checkOutput("singleAck", acks, 1);
        checkOutput("curSelLatest", int'(cur_sel), 3);

        // Reserved code behaves as /16 and reads back as written.
        clksel = 3'd6;
        waitSelRun(3'd6);
        checkOutput("curSelReserved", int'(cur_sel), 6);
        measureGap(gap);
        checkOutput("gapReserved", gap, 16);

        // One-cycle lock loss while running.
        clksel = 3'd4;
        waitSelRun(3'd4);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 1;
        while (run_resn && n < 40) begin
            step();
            n++;
        end
        checkOutput("dropLatency", n, 4);
        while (!run_resn && n < 60) begin
            step();
            n++;
        end
        checkOutput("relockLatency", n, 12);

        // Asynchronous reset mid-run, then recovery.
        step();
        #2;
        nres = 1'b0;
        #1;
        checkOutput("asyncRunResn", int'(run_resn), 0);
        checkOutput("asyncClkEn",   int'(clk_en),   0);
        checkOutput("asyncCurSel",  int'(cur_sel),  0);
        checkOutput("asyncSelAck",  int'(sel_ack),  0);
        step();
        nres = 1'b1;
        edgesUntilRun(1'b1, 40, n);
        checkOutput("recoverLatency", n, 11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_160);
            checkOutput("recoverDiv1", int'(clk_en), 1);
        end

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
